key_lut_pipe: RTL and testbench

KEY_LUT_PIPE -- requirements
Module: key_lut_pipe

---
 rtl/key_lut_pipe_pkg.sv | 11 +
 rtl/key_lut_pipe_prio_enc.sv | 25 ++
 rtl/key_lut_pipe.sv | 110 +++++++++++
 tb/tb_key_lut_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_lut_pipe_pkg.sv
`default_nettype none
// Shared helpers for key_lut_pipe. Table types stay per-instance because
// every width depends on the instance parameters.
package key_lut_pipe_pkg;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_lut_pipe_prio_enc.sv
`default_nettype none
// prio_enc: lowest set bit of a multi-hot request vector -> index plus any-set flag.
module prio_enc #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan from the top so the lowest set bit is the last one to win.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/key_lut_pipe.sv
`default_nettype none
// key_lut_pipe: NR_KEY-entry key->data lookup table with a one-deep
// registered valid/ready result stage and a saturating miss counter.
module key_lut_pipe
  import key_lut_pipe_pkg::*;
#(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 8,
  parameter int DATA_LEN = 32,
  parameter int CNT_LEN  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_clr,
  input  logic                      i_wr_en,
  input  logic [$clog2(NR_KEY)-1:0] i_wr_idx,
  input  logic [KEY_LEN-1:0]        i_wr_key,
  input  logic [DATA_LEN-1:0]       i_wr_data,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [KEY_LEN-1:0]        i_key,
  input  logic [DATA_LEN-1:0]       i_default,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [DATA_LEN-1:0]       o_data,
  output logic                      o_hit,
  output logic [$clog2(NR_KEY)-1:0] o_idx,
  output logic [CNT_LEN-1:0]        o_miss_cnt
);

  localparam int IDX_W = idx_width(NR_KEY);

  typedef struct packed {
    logic [KEY_LEN-1:0]  key;
    logic [DATA_LEN-1:0] data;
  } entry_t;

  entry_t             entries [NR_KEY];
  logic [NR_KEY-1:0]  entry_vld;
  logic [NR_KEY-1:0]  match;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_hit;
  logic               accept;
  logic               wr_ok;

  assign o_ready = ~o_valid | i_ready;
  assign accept  = i_valid & o_ready;
  // Indices past the last entry exist only when NR_KEY is not a power of two.
  assign wr_ok   = i_wr_en & ({1'b0, i_wr_idx} < (IDX_W + 1)'(NR_KEY));

  // Write is applied after clear so a same-edge write survives it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      entry_vld <= '0;
    end else begin
      if (i_clr) begin
        entry_vld <= '0;
      end
      if (wr_ok) begin
        entry_vld[i_wr_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok) begin
      entries[i_wr_idx] <= '{key: i_wr_key, data: i_wr_data};
    end
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      match[i] = entry_vld[i] && (entries[i].key == i_key);
    end
  end

  prio_enc #(
    .N (NR_KEY),
    .W (IDX_W)
  ) u_prio_enc (
    .req (match),
    .idx (sel_idx),
    .any (sel_hit)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid    <= 1'b0;
      o_hit      <= 1'b0;
      o_idx      <= '0;
      o_data     <= '0;
      o_miss_cnt <= '0;
    end else begin
      if (accept) begin
        o_valid <= 1'b1;
        o_hit   <= sel_hit;
        o_idx   <= sel_hit ? sel_idx : '0;
        o_data  <= sel_hit ? entries[sel_idx].data : i_default;
        if (!sel_hit && (o_miss_cnt != '1)) begin
          o_miss_cnt <= o_miss_cnt + 1'b1;
        end
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_lut_pipe.sv
`default_nettype none
// tb_key_lut_pipe: scoreboard bench with a table-level reference model.
module tb_key_lut_pipe;

  localparam int NR_KEY   = 5;
  localparam int KEY_LEN  = 8;
  localparam int DATA_LEN = 32;
  localparam int CNT_LEN  = 2;
  localparam int IDX_W    = $clog2(NR_KEY);
  localparam int CNT_MAX  = (1 << CNT_LEN) - 1;

  typedef struct {
    logic                hit;
    logic [IDX_W-1:0]    idx;
    logic [DATA_LEN-1:0] data;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                clr, wr_en, vld, rdy;
  logic [IDX_W-1:0]    wr_idx;
  logic [KEY_LEN-1:0]  wr_key, key;
  logic [DATA_LEN-1:0] wr_data, dflt;
  logic                o_ready, o_valid, o_hit;
  logic [DATA_LEN-1:0] o_data;
  logic [IDX_W-1:0]    o_idx;
  logic [CNT_LEN-1:0]  o_miss_cnt;

  key_lut_pipe #(
    .NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN), .CNT_LEN(CNT_LEN)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_wr_en(wr_en),
    .i_wr_idx(wr_idx), .i_wr_key(wr_key), .i_wr_data(wr_data),
    .i_valid(vld), .o_ready(o_ready), .i_key(key), .i_default(dflt),
    .o_valid(o_valid), .i_ready(rdy), .o_data(o_data), .o_hit(o_hit),
    .o_idx(o_idx), .o_miss_cnt(o_miss_cnt)
  );

  always #5 clk = ~clk;

  // Reference table and counters
  logic                m_valid [NR_KEY];
  logic [KEY_LEN-1:0]  m_key   [NR_KEY];
  logic [DATA_LEN-1:0] m_data  [NR_KEY];
  int                  m_miss;
  exp_t                sb [$];
  int                  n_tests = 0;
  int                  n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_lookup(input logic [KEY_LEN-1:0] k, input logic [DATA_LEN-1:0] d);
    exp_t e;
    e.hit  = 1'b0;
    e.idx  = '0;
    e.data = d;
    for (int i = 0; i < NR_KEY; i++) begin
      if (!e.hit && m_valid[i] && m_key[i] == k) begin
        e.hit  = 1'b1;
        e.idx  = IDX_W'(i);
        e.data = m_data[i];
      end
    end
    return e;
  endfunction

  task automatic model_clear_all();
    for (int i = 0; i < NR_KEY; i++) m_valid[i] = 1'b0;
    m_miss = 0;
    sb.delete();
  endtask

  // Monitor: inputs change at posedge+3, so the negedge sees settled values.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("o_valid", 64'(o_valid), 64'(sb.size() != 0));
        chk("o_ready", 64'(o_ready), 64'((sb.size() == 0) || rdy));
        chk("o_miss_cnt", 64'(o_miss_cnt), 64'(m_miss));
        if (sb.size() != 0) begin
          chk("o_hit", 64'(o_hit), 64'(sb[0].hit));
          chk("o_idx", 64'(o_idx), 64'(sb[0].idx));
          chk("o_data", 64'(o_data), 64'(sb[0].data));
          if (rdy) void'(sb.pop_front());
        end
      end
    end
  end

  // One clock: starts and ends at posedge+3 with inputs already applied.
  task automatic cycle();
    logic acc;
    exp_t e;
    @(negedge clk);
    acc = vld && o_ready;
    if (acc) e = model_lookup(key, dflt);
    @(posedge clk);
    #1;
    if (acc) begin
      sb.push_back(e);
      if (!e.hit && m_miss < CNT_MAX) m_miss++;
    end
    if (clr) for (int i = 0; i < NR_KEY; i++) m_valid[i] = 1'b0;
    if (wr_en && int'(wr_idx) < NR_KEY) begin
      m_valid[wr_idx] = 1'b1;
      m_key[wr_idx]   = wr_key;
      m_data[wr_idx]  = wr_data;
    end
    #2;
  endtask

  task automatic idle();
    clr = 0; wr_en = 0; vld = 0; rdy = 1;
    wr_idx = '0; wr_key = '0; wr_data = '0; key = '0; dflt = '0;
  endtask

  task automatic write(input int idx, input logic [KEY_LEN-1:0] k, input logic [DATA_LEN-1:0] d);
    idle();
    wr_en = 1; wr_idx = IDX_W'(idx); wr_key = k; wr_data = d;
    cycle();
  endtask

  task automatic lookup(input logic [KEY_LEN-1:0] k, input logic [DATA_LEN-1:0] d);
    idle();
    vld = 1; key = k; dflt = d;
    cycle();
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    #1;
    model_clear_all();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    model_clear_all();
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1;
    chk("reset o_valid", 64'(o_valid), 64'd0);
    chk("reset o_hit", 64'(o_hit), 64'd0);
    chk("reset o_idx", 64'(o_idx), 64'd0);
    chk("reset o_data", 64'(o_data), 64'd0);
    chk("reset o_miss_cnt", 64'(o_miss_cnt), 64'd0);
    chk("reset o_ready", 64'(o_ready), 64'd1);

    // Basic hit
    write(0, 8'h12, 32'hAAAA0000);
    lookup(8'h12, 32'h0);
    chk("hit valid", 64'(o_valid), 64'd1);
    chk("hit flag", 64'(o_hit), 64'd1);
    chk("hit idx", 64'(o_idx), 64'd0);
    chk("hit data", 64'(o_data), 64'hAAAA0000);

    // Duplicate keys: lowest index wins
    write(1, 8'h34, 32'h1111);
    write(3, 8'h34, 32'h3333);
    lookup(8'h34, 32'h0);
    chk("dup idx", 64'(o_idx), 64'd1);
    chk("dup data", 64'(o_data), 64'h1111);

    // Misses on an empty table
    do_reset();
    lookup(8'h99, 32'hDEAD);
    lookup(8'h99, 32'hDEAD);
    lookup(8'h99, 32'hDEAD);
    chk("miss data", 64'(o_data), 64'hDEAD);
    chk("miss hit", 64'(o_hit), 64'd0);
    idle(); cycle();
    chk("miss cnt 3", 64'(o_miss_cnt), 64'd3);

    // Out-of-range write index is dropped
    write(5, 8'h66, 32'h6666);
    write(7, 8'h66, 32'h7777);
    lookup(8'h66, 32'hBEEF);
    chk("oob write ignored", 64'(o_hit), 64'd0);

    // Backpressure then release
    write(2, 8'hA0, 32'hA0A0);
    write(4, 8'hB0, 32'hB0B0);
    idle();
    vld = 1; rdy = 0; key = 8'hA0; dflt = 32'h5;
    cycle();
    for (int i = 0; i < 3; i++) begin
      key = (i % 2 == 0) ? 8'hB0 : 8'h77;
      cycle();
    end
    chk("stall o_ready", 64'(o_ready), 64'd0);
    chk("stall o_data", 64'(o_data), 64'hA0A0);
    rdy = 1;
    for (int i = 0; i < 4; i++) begin
      key = (i % 2 == 0) ? 8'hB0 : 8'hA0;
      cycle();
    end
    idle(); cycle(); cycle();

    // Same-cycle write and lookup sees the old table
    idle();
    wr_en = 1; wr_idx = 3'd2; wr_key = 8'h55; wr_data = 32'h5555;
    vld = 1; key = 8'h55; dflt = 32'hD0;
    cycle();
    chk("same-cycle miss", 64'(o_hit), 64'd0);
    lookup(8'h55, 32'hD0);
    chk("after write hit", 64'(o_hit), 64'd1);
    chk("after write idx", 64'(o_idx), 64'd2);

    // Clear with simultaneous write keeps only the written entry
    idle();
    clr = 1; wr_en = 1; wr_idx = 3'd0; wr_key = 8'h77; wr_data = 32'h7070;
    cycle();
    lookup(8'h55, 32'hC1);
    chk("clr drops idx2", 64'(o_hit), 64'd0);
    lookup(8'h77, 32'hC2);
    chk("clr keeps idx0", 64'(o_hit), 64'd1);

    // Saturation and reset of a stalled result
    do_reset();
    for (int i = 0; i < 5; i++) lookup(8'hEE, 32'(i));
    idle(); cycle();
    chk("miss saturate", 64'(o_miss_cnt), 64'd3);
    idle();
    vld = 1; rdy = 0; key = 8'hEE; dflt = 32'hFACE;
    cycle();
    vld = 0;
    rst_n = 0;
    #1;
    chk("async rst o_valid", 64'(o_valid), 64'd0);
    chk("async rst miss", 64'(o_miss_cnt), 64'd0);
    chk("async rst o_ready", 64'(o_ready), 64'd1);
    model_clear_all();
    @(posedge clk);
    #3;
    rst_n = 1;

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      clr     = ($urandom_range(0, 31) == 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_idx  = IDX_W'($urandom_range(0, 7));
      wr_key  = KEY_LEN'($urandom_range(0, 7));
      wr_data = $urandom;
      vld     = ($urandom_range(0, 3) != 0);
      rdy     = ($urandom_range(0, 3) != 0);
      key     = KEY_LEN'($urandom_range(0, 7));
      dflt    = $urandom;
      cycle();
    end

    idle();
    repeat (3) cycle();
    chk("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
